mem_req_arbiter: RTL and testbench

- Initiator-side master for the shared memory request/response interface: mem_req_valid/addr/write/data out, mem_resp_valid/data in.
- Arbitrates round-robin between NUM_REQ cache controllers, serialises one transaction at a time onto memory, and returns read data or write acknowledgements to the granted requester.
- Sits between the per-core cache controllers and the memory model in the coherence subsystem.

---
 rtl/mem_req_arbiter_pkg.sv | 19 +
 rtl/mem_req_arbiter_rr_arbiter.sv | 31 +++
 rtl/mem_req_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_req_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and sizing helpers for the memory request arbiter.
package mem_req_pkg;

   localparam int DEFAULT_ADDRESS_WIDTH = 6;
   localparam int DEFAULT_DATA_WIDTH    = 32;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITE     = 2'd1,
      READ_WAIT = 2'd2,
      GAP       = 2'd3
   } state_t;

   // Wide enough to hold the value TIMEOUT_CYCLES itself.
   function automatic int timeout_cnt_w(input int timeout_cycles);
      return $clog2(timeout_cycles + 1);
   endfunction

endpackage

// File: rtl/mem_req_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first requester after last_grant
// (with wrap) wins; the grant is one-hot, or zero when disabled or idle.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_last_grant,
   input  logic               i_enable,
   output logic [NUM_REQ-1:0] o_grant
);

   int w_dist;
   int w_best;

   // Distance 0 is the requester immediately after last_grant.
   always_comb begin
      o_grant = '0;
      w_dist  = 0;
      w_best  = NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_dist = (i + NUM_REQ - 1 - int'(i_last_grant)) % NUM_REQ;
         if (i_enable && i_req[i] && (w_dist < w_best)) begin
            w_best     = w_dist;
            o_grant    = '0;
            o_grant[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin master that serialises cache-controller requests onto a single
// memory port and returns read data / write acks to the owning requester.
module mem_req_arbiter
   import mem_req_pkg::*;
#(
   parameter int ADDRESS_WIDTH  = DEFAULT_ADDRESS_WIDTH,
   parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                             i_clk,
   input  logic                             i_reset,
   input  logic [NUM_REQ-1:0]               i_req_valid,
   output logic [NUM_REQ-1:0]               o_req_ready,
   input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] i_req_addr,
   input  logic [NUM_REQ-1:0]               i_req_write,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    i_req_wdata,
   output logic [NUM_REQ-1:0]               o_resp_valid,
   output logic [DATA_WIDTH-1:0]            o_resp_data,
   output logic                             o_mem_req_valid,
   output logic [ADDRESS_WIDTH-1:0]         o_mem_req_addr,
   output logic                             o_mem_req_write,
   output logic [DATA_WIDTH-1:0]            o_mem_req_data,
   input  logic                             i_mem_resp_valid,
   input  logic [DATA_WIDTH-1:0]            i_mem_resp_data,
   output logic                             o_timeout_err,
   output logic [1:0]                       o_state
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = timeout_cnt_w(TIMEOUT_CYCLES);

   state_t                   r_state, w_next_state;
   logic [IDX_W-1:0]         r_last_grant, r_owner, w_gidx;
   logic [CNT_W-1:0]         r_wait_cnt;
   logic [NUM_REQ-1:0]       r_resp_valid, w_grant;
   logic [DATA_WIDTH-1:0]    r_resp_data, r_mem_req_data, w_sel_wdata;
   logic [ADDRESS_WIDTH-1:0] r_mem_req_addr, w_sel_addr;
   logic                     r_mem_req_valid, r_mem_req_write, r_timeout_err;
   logic                     w_sel_write, w_accept, w_timeout;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
      .i_req        (i_req_valid),
      .i_last_grant (r_last_grant),
      .i_enable     (r_state == IDLE),
      .o_grant      (w_grant)
   );

   // The grant is one-hot, so the payload mux is a simple OR-select.
   always_comb begin
      w_gidx      = '0;
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      w_sel_write = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant[i]) begin
            w_gidx      = IDX_W'(i);
            w_sel_addr  = i_req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            w_sel_wdata = i_req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            w_sel_write = i_req_write[i];
         end
      end
   end

   always_comb begin
      w_next_state = r_state;
      o_req_ready  = '0;
      w_accept     = 1'b0;
      w_timeout    = 1'b0;
      case (r_state)
         IDLE: begin
            o_req_ready = w_grant;
            if (|w_grant) begin
               w_accept     = 1'b1;
               w_next_state = w_sel_write ? WRITE : READ_WAIT;
            end
         end
         WRITE: w_next_state = GAP;
         READ_WAIT: begin
            if (i_mem_resp_valid) begin
               w_next_state = GAP;
            end else if (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               w_next_state = GAP;
               w_timeout    = 1'b1;
            end
         end
         GAP:     w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Outputs are computed from the next state so they are registered yet
   // line up with the state they belong to.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state         <= IDLE;
         r_last_grant    <= IDX_W'(NUM_REQ - 1);
         r_owner         <= '0;
         r_wait_cnt      <= '0;
         r_resp_valid    <= '0;
         r_resp_data     <= '0;
         r_mem_req_valid <= 1'b0;
         r_mem_req_write <= 1'b0;
         r_mem_req_addr  <= '0;
         r_mem_req_data  <= '0;
         r_timeout_err   <= 1'b0;
      end else begin
         r_state         <= w_next_state;
         r_mem_req_valid <= (w_next_state == WRITE) || (w_next_state == READ_WAIT);
         r_mem_req_write <= (w_next_state == WRITE);
         r_wait_cnt      <= (r_state == READ_WAIT) ? r_wait_cnt + CNT_W'(1) : '0;
         r_resp_valid    <= '0;
         if (w_accept) begin
            r_owner        <= w_gidx;
            r_last_grant   <= w_gidx;
            r_mem_req_addr <= w_sel_addr;
            r_mem_req_data <= w_sel_wdata;
         end
         if ((w_next_state == GAP) && (r_state != GAP)) begin
            r_resp_valid <= NUM_REQ'(1) << r_owner;
         end
         if ((r_state == READ_WAIT) && (w_next_state == GAP)) begin
            if (w_timeout) begin
               r_resp_data   <= '0;
               r_timeout_err <= 1'b1;
            end else begin
               r_resp_data <= i_mem_resp_data;
            end
         end
      end
   end

   assign o_resp_valid    = r_resp_valid;
   assign o_resp_data     = r_resp_data;
   assign o_mem_req_valid = r_mem_req_valid;
   assign o_mem_req_addr  = r_mem_req_addr;
   assign o_mem_req_write = r_mem_req_write;
   assign o_mem_req_data  = r_mem_req_data;
   assign o_timeout_err   = r_timeout_err;
   assign o_state         = r_state;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter with a 4-cycle read memory model that
// can be muted to provoke the read timeout.
module tb_mem_req_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_valid, req_ready, req_write, resp_valid;
   logic [11:0] req_addr;
   logic [63:0] req_wdata;
   logic [31:0] resp_data, mem_req_data, mem_resp_data;
   logic [5:0]  mem_req_addr;
   logic        mem_req_valid, mem_req_write, mem_resp_valid, timeout_err;
   logic [1:0]  state;

   logic [31:0] mem [64];
   int          mem_cnt = 0;
   int          wr_pulses = 0;
   int          cyc = 0;
   logic        mem_en;
   int          total = 0;
   int          bad = 0;

   logic [1:0]  exp_g [3] = '{2'b01, 2'b10, 2'b01};
   logic [31:0] exp_d [3] = '{32'd30, 32'd70, 32'd30};

   always #5 clk = ~clk;

   mem_req_arbiter dut (
      .i_clk            (clk),
      .i_reset          (reset),
      .i_req_valid      (req_valid),
      .o_req_ready      (req_ready),
      .i_req_addr       (req_addr),
      .i_req_write      (req_write),
      .i_req_wdata      (req_wdata),
      .o_resp_valid     (resp_valid),
      .o_resp_data      (resp_data),
      .o_mem_req_valid  (mem_req_valid),
      .o_mem_req_addr   (mem_req_addr),
      .o_mem_req_write  (mem_req_write),
      .o_mem_req_data   (mem_req_data),
      .i_mem_resp_valid (mem_resp_valid),
      .i_mem_resp_data  (mem_resp_data),
      .o_timeout_err    (timeout_err),
      .o_state          (state)
   );

   // Memory: contents addr*10 after reset, read response on the 4th request cycle.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset) begin
         for (int a = 0; a < 64; a++) mem[a] <= 32'(a * 10);
         mem_cnt        <= 0;
         mem_resp_valid <= 1'b0;
         mem_resp_data  <= '0;
      end else begin
         if (mem_req_valid && mem_req_write) begin
            mem[mem_req_addr] <= mem_req_data;
            wr_pulses         <= wr_pulses + 1;
         end
         if (mem_req_valid && !mem_req_write && mem_en) begin
            if (mem_cnt == 3) begin
               mem_resp_valid <= 1'b1;
               mem_resp_data  <= mem[mem_req_addr];
            end else begin
               mem_resp_valid <= 1'b0;
            end
            if (mem_cnt < 4) mem_cnt <= mem_cnt + 1;
         end else begin
            mem_resp_valid <= 1'b0;
            mem_cnt        <= 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Presents a request, waits (bounded) for its ready, and returns in cycle T+1.
   task automatic issue(input int r, input logic w, input logic [5:0] a, input logic [31:0] d);
      int n;
      req_valid[r]         = 1'b1;
      req_write[r]         = w;
      req_addr[r*6 +: 6]   = a;
      req_wdata[r*32 +: 32] = d;
      n = 0;
      #1;
      while (!req_ready[r] && n < 50) begin
         tick();
         n++;
      end
      chk("accept_wait", 32'(n < 50), 32'd1);
      tick();
      req_valid[r] = 1'b0;
   endtask

   task automatic wait_resp(output int n);
      n = 0;
      while (resp_valid == 2'b00 && n < 40) begin
         tick();
         n++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int acc [4];
      int wr0;
      reset     = 1'b1;
      req_valid = '0;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;
      mem_en    = 1'b1;
      tick(); tick();
      chk("rst_mem_valid", 32'(mem_req_valid), 32'd0);
      chk("rst_mem_addr", 32'(mem_req_addr), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      chk("rst_timeout", 32'(timeout_err), 32'd0);
      chk("rst_state", 32'(state), 32'd0);
      reset = 1'b0;
      tick();

      // Read addr 5 from requester 0.
      issue(0, 1'b0, 6'd5, 32'd0);
      for (int k = 1; k <= 5; k++) begin
         chk("rd_mem_valid", 32'(mem_req_valid), 32'd1);
         chk("rd_mem_addr", 32'(mem_req_addr), 32'd5);
         chk("rd_no_resp", 32'(resp_valid), 32'd0);
         tick();
      end
      chk("rd_resp_valid", 32'(resp_valid), 32'b01);
      chk("rd_resp_data", resp_data, 32'd50);
      chk("rd_gap_valid", 32'(mem_req_valid), 32'd0);
      tick();
      chk("rd_idle_state", 32'(state), 32'd0);
      chk("rd_resp_clear", 32'(resp_valid), 32'd0);

      // Write from requester 1, then read it back.
      issue(1, 1'b1, 6'd12, 32'hDEADBEEF);
      chk("wr_mem_valid", 32'(mem_req_valid), 32'd1);
      chk("wr_mem_write", 32'(mem_req_write), 32'd1);
      chk("wr_mem_addr", 32'(mem_req_addr), 32'd12);
      chk("wr_mem_data", mem_req_data, 32'hDEADBEEF);
      tick();
      chk("wr_ack", 32'(resp_valid), 32'b10);
      chk("wr_ack_data_kept", resp_data, 32'd50);
      chk("wr_gap_valid", 32'(mem_req_valid), 32'd0);
      tick();
      chk("wr_idle_state", 32'(state), 32'd0);
      chk("wr_mem12", mem[12], 32'hDEADBEEF);
      issue(1, 1'b0, 6'd12, 32'd0);
      wait_resp(n);
      chk("rb_latency", 32'(n), 32'd5);
      chk("rb_resp_valid", 32'(resp_valid), 32'b10);
      chk("rb_resp_data", resp_data, 32'hDEADBEEF);
      tick();

      // Both requesters hold reads: grants rotate 0,1,0.
      req_write = 2'b00;
      req_addr  = {6'd7, 6'd3};
      req_valid = 2'b11;
      for (int j = 0; j < 3; j++) begin
         #1;
         chk("rr_ready_now", 32'(req_ready), 32'(exp_g[j]));
         tick();
         wait_resp(n);
         chk("rr_latency", 32'(n), 32'd5);
         chk("rr_resp_valid", 32'(resp_valid), 32'(exp_g[j]));
         chk("rr_resp_data", resp_data, exp_d[j]);
         chk("rr_gap_valid", 32'(mem_req_valid), 32'd0);
         tick();
      end
      req_valid = 2'b00;
      tick();

      // Silent memory: read times out after 16 wait cycles.
      mem_en = 1'b0;
      issue(0, 1'b0, 6'd9, 32'd0);
      wait_resp(n);
      chk("to_latency", 32'(n), 32'd16);
      chk("to_resp_valid", 32'(resp_valid), 32'b01);
      chk("to_resp_data", resp_data, 32'd0);
      chk("to_err", 32'(timeout_err), 32'd1);
      mem_en = 1'b1;
      tick(); tick(); tick();
      chk("to_err_sticky", 32'(timeout_err), 32'd1);
      chk("to_idle_state", 32'(state), 32'd0);

      // Reset in the middle of a read.
      issue(0, 1'b0, 6'd2, 32'd0);
      tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mr_mem_valid", 32'(mem_req_valid), 32'd0);
      chk("mr_resp_valid", 32'(resp_valid), 32'd0);
      chk("mr_resp_data", resp_data, 32'd0);
      chk("mr_timeout", 32'(timeout_err), 32'd0);
      chk("mr_state", 32'(state), 32'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("mr_no_resp", 32'(resp_valid), 32'd0);
      end
      issue(0, 1'b0, 6'd1, 32'd0);
      wait_resp(n);
      chk("mr_fresh_valid", 32'(resp_valid), 32'b01);
      chk("mr_fresh_data", resp_data, 32'd10);
      tick();

      // Back-to-back writes from requester 0.
      wr0          = wr_pulses;
      req_valid[0] = 1'b1;
      req_write[0] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_addr[5:0]   = 6'(i);
         req_wdata[31:0] = 32'h100 + 32'(i);
         n = 0;
         #1;
         while (!req_ready[0] && n < 20) begin
            tick();
            n++;
         end
         chk("b2b_accept_wait", 32'(n < 20), 32'd1);
         acc[i] = cyc;
         tick();
      end
      req_valid = 2'b00;
      tick(); tick(); tick();
      for (int i = 1; i < 4; i++) chk("b2b_spacing", 32'(acc[i] - acc[i-1]), 32'd3);
      chk("b2b_pulses", 32'(wr_pulses - wr0), 32'd4);
      for (int i = 0; i < 4; i++) chk("b2b_mem", mem[i], 32'h100 + 32'(i));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
